// File: rtl/viterbi_pmu_sr_if.sv
// Branch-in / decision-out bundle for viterbi_pmu_sr.
// The block itself is the slave; the branch-metric source and decision sink form the master.
interface viterbi_pmu_sr_if #(
  parameter int SW   = 2,
  parameter int BM_W = 3,
  parameter int PM_W = 6
) ();
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_state;
  logic            in_bit;
  logic [BM_W-1:0] in_bm;
  logic            in_last;
  logic            out_valid;
  logic            out_bit;
  logic [SW-1:0]   out_state;
  logic [PM_W-1:0] out_metric;

  modport master (
    output in_valid, in_state, in_bit, in_bm, in_last,
    input  in_ready, out_valid, out_bit, out_state, out_metric
  );

  modport slave (
    input  in_valid, in_state, in_bit, in_bm, in_last,
    output in_ready, out_valid, out_bit, out_state, out_metric
  );
endinterface

// File: rtl/viterbi_pmu_sr.sv
// viterbi_pmu_sr: serial add-compare-select path-metric unit with register-exchange survivors.
// Optional VITERBI_PMU_NORM_EN subtracts the minimum metric from every state at each commit.
module viterbi_pmu_sr #(
  parameter int K        = 3,
  parameter int BM_W     = 3,
  parameter int PM_W     = 6,
  parameter int SURV_D   = 13,
  parameter int INIT_PEN = 3
) (
  input logic             clk,
  input logic             rst,
  viterbi_pmu_sr_if.slave bus
);
  localparam int NS    = 1 << (K - 1);
  localparam int SW    = K - 1;
  localparam int SUM_W = ((PM_W > BM_W) ? PM_W : BM_W) + 1;
  localparam int FW    = $clog2(SURV_D + 1);
  localparam logic [PM_W-1:0] PM_MAX   = {PM_W{1'b1}};
  localparam logic [FW-1:0]   FILL_MAX = FW'(SURV_D);

  typedef enum logic [0:0] {ACC = 1'b0, COMMIT = 1'b1} state_e;

  state_e            st_q, st_d;
  logic [PM_W-1:0]   pm_q  [NS];
  logic [PM_W-1:0]   pm_d  [NS];
  logic [PM_W-1:0]   nm_q  [NS];
  logic [PM_W-1:0]   nm_d  [NS];
  logic [SURV_D-1:0] sv_q  [NS];
  logic [SURV_D-1:0] sv_d  [NS];
  logic [SURV_D-1:0] nsv_q [NS];
  logic [SURV_D-1:0] nsv_d [NS];
  logic [NS-1:0]     wr_q, wr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic [SW-1:0]     out_state_q, out_state_d;
  logic [PM_W-1:0]   out_metric_q, out_metric_d;

  logic              accept_s, take_s, lt_s;
  logic [SW:0]       cat_s;
  logic [SW-1:0]     ns_s, best_s;
  logic [SUM_W-1:0]  sum_s;
  logic [PM_W-1:0]   cand_s, min_s;
  logic [FW-1:0]     fill_inc_s;

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bit    = out_bit_q;
  assign bus.out_state  = out_state_q;
  assign bus.out_metric = out_metric_q;

  // Saturating candidate, next-state index and lowest-index minimum search.
  always_comb begin
    accept_s = bus.in_valid && in_ready_q;
    cat_s    = {bus.in_bit, bus.in_state};
    ns_s     = cat_s[SW:1];
    sum_s    = SUM_W'(pm_q[bus.in_state]) + SUM_W'(bus.in_bm);
    cand_s   = (sum_s > SUM_W'(PM_MAX)) ? PM_MAX : sum_s[PM_W-1:0];
    // Strict less-than: on a tie the earlier arrival keeps the state.
    take_s   = !wr_q[ns_s] || (cand_s < nm_q[ns_s]);
    min_s    = nm_q[0];
    best_s   = {SW{1'b0}};
    lt_s     = 1'b0;
    for (int i = 1; i < NS; i++) begin
      lt_s   = nm_q[i] < min_s;
      best_s = lt_s ? SW'(i) : best_s;
      min_s  = lt_s ? nm_q[i] : min_s;
    end
    fill_inc_s = (fill_q == FILL_MAX) ? fill_q : fill_q + {{(FW-1){1'b0}}, 1'b1};
  end

  // Next-state logic: ACS accumulation in ACC, metric/survivor commit in COMMIT.
  always_comb begin
    st_d         = st_q;
    pm_d         = pm_q;
    nm_d         = nm_q;
    sv_d         = sv_q;
    nsv_d        = nsv_q;
    wr_d         = wr_q;
    fill_d       = fill_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = 1'b0;
    out_bit_d    = out_bit_q;
    out_state_d  = out_state_q;
    out_metric_d = out_metric_q;
    case (st_q)
      ACC: begin
        if (accept_s) begin
          if (take_s) begin
            nm_d[ns_s]  = cand_s;
            wr_d[ns_s]  = 1'b1;
            nsv_d[ns_s] = {sv_q[bus.in_state][SURV_D-2:0], bus.in_bit};
          end else begin
            wr_d = wr_q;
          end
          if (bus.in_last) begin
            st_d       = COMMIT;
            in_ready_d = 1'b0;
          end else begin
            st_d       = ACC;
            in_ready_d = 1'b1;
          end
        end else begin
          st_d = ACC;
        end
      end
      COMMIT: begin
        for (int i = 0; i < NS; i++) begin
`ifdef VITERBI_PMU_NORM_EN
          pm_d[i] = nm_q[i] - min_s;
`else
          pm_d[i] = nm_q[i];
`endif
          nm_d[i] = PM_MAX;
        end
        sv_d         = nsv_q;
        wr_d         = {NS{1'b0}};
        out_metric_d = min_s;
        out_state_d  = best_s;
        out_bit_d    = nsv_q[best_s][SURV_D-1];
        fill_d       = fill_inc_s;
        out_valid_d  = (fill_inc_s >= FILL_MAX);
        st_d         = ACC;
        in_ready_d   = 1'b1;
      end
      default: begin
        st_d       = ACC;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State register with synchronous reset; a mid-symbol reset drops all partial ACS results.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ACC;
      for (int i = 0; i < NS; i++) begin
        pm_q[i]  <= (i == 0) ? {PM_W{1'b0}} : PM_W'(INIT_PEN);
        nm_q[i]  <= PM_MAX;
        sv_q[i]  <= {SURV_D{1'b0}};
        nsv_q[i] <= {SURV_D{1'b0}};
      end
      wr_q         <= {NS{1'b0}};
      fill_q       <= {FW{1'b0}};
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_state_q  <= {SW{1'b0}};
      out_metric_q <= {PM_W{1'b0}};
    end else begin
      st_q         <= st_d;
      pm_q         <= pm_d;
      nm_q         <= nm_d;
      sv_q         <= sv_d;
      nsv_q        <= nsv_d;
      wr_q         <= wr_d;
      fill_q       <= fill_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_bit_q    <= out_bit_d;
      out_state_q  <= out_state_d;
      out_metric_q <= out_metric_d;
    end
  end
endmodule
